// File: rtl/bat_program_loader_if.sv
// Stream-in and RAM-bus signal bundle for bat_program_loader.
// The master side is the loader; the slave side is the byte source plus RAM/CPU.
interface bat_program_loader_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
);
  logic [7:0]               IN_BYTE;
  logic                     IN_VALID;
  logic                     IN_READY;
  logic                     RESTART;
  logic [ADDRESS_WIDTH-1:0] ADDR_OUT;
  logic [DATA_WIDTH-1:0]    DATA_OUT;
  logic                     BUS_OE;
  logic                     RAM_EN;
  logic                     RAM_RW;
  logic                     HALT;
  logic                     DONE;
  logic                     ERROR;

  modport master (
    input  IN_BYTE, IN_VALID, RESTART,
    output IN_READY, ADDR_OUT, DATA_OUT, BUS_OE, RAM_EN, RAM_RW, HALT, DONE, ERROR
  );

  modport slave (
    output IN_BYTE, IN_VALID, RESTART,
    input  IN_READY, ADDR_OUT, DATA_OUT, BUS_OE, RAM_EN, RAM_RW, HALT, DONE, ERROR
  );
endinterface

// File: rtl/bat_program_loader.sv
// Boot loader: streams {start, count, words} into RAM while holding the CPU in HALT.
// Optional BAT_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte and a FAIL state.
module bat_program_loader #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
) (
  input logic                  CLK,
  input logic                  RESET,
  bat_program_loader_if.master bus
);
  typedef enum logic [3:0] {
    S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO,
    S_WRITE, S_CHK, S_RELEASE, S_RUN, S_GRAB, S_FAIL
  } state_t;

`ifdef BAT_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_RELEASE;
`endif

  state_t state, state_nxt;
  logic   in_ready_r, bus_oe_r, ram_en_r, ram_rw_r, halt_r, done_r;
  logic   in_ready_nxt, bus_oe_nxt, ram_en_nxt, ram_rw_nxt, halt_nxt, done_nxt;

  logic [7:0]               hi_byte;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [15:0]              count;
  logic [DATA_WIDTH-1:0]    data;
  logic [15:0]              word;
  logic                     accept;

  assign accept = bus.IN_VALID && in_ready_r;
  assign word   = {hi_byte, bus.IN_BYTE};

`ifdef BAT_LOADER_CHECKSUM_EN
  logic [7:0] sum, chk_sum;
  logic       err, err_nxt;
  assign chk_sum = sum + bus.IN_BYTE;
`endif

  always_comb begin
    state_nxt = state;
`ifdef BAT_LOADER_CHECKSUM_EN
    err_nxt   = err;
`endif
    case (state)
      S_ADDR_HI: if (accept) state_nxt = S_ADDR_LO;
      S_ADDR_LO: if (accept) state_nxt = S_CNT_HI;
      S_CNT_HI:  if (accept) state_nxt = S_CNT_LO;
      S_CNT_LO:  if (accept) state_nxt = (word == 16'd0) ? S_END : S_DATA_HI;
      S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
      S_DATA_LO: if (accept) state_nxt = S_WRITE;
      S_WRITE:   state_nxt = (count == 16'd1) ? S_END : S_DATA_HI;
      S_CHK: begin
        if (accept) begin
`ifdef BAT_LOADER_CHECKSUM_EN
          if (chk_sum != 8'h00) err_nxt = 1'b1;
`endif
          state_nxt = S_RELEASE;
        end
      end
`ifdef BAT_LOADER_CHECKSUM_EN
      S_RELEASE: state_nxt = err ? S_FAIL : S_RUN;
`else
      S_RELEASE: state_nxt = S_RUN;
`endif
      S_RUN:     if (bus.RESTART) state_nxt = S_GRAB;
      S_GRAB:    state_nxt = S_ADDR_HI;
      S_FAIL: begin
        if (bus.RESTART) begin
          state_nxt = S_GRAB;
`ifdef BAT_LOADER_CHECKSUM_EN
          err_nxt   = 1'b0;
`endif
        end
      end
      default:   state_nxt = S_ADDR_HI;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    in_ready_nxt = 1'b0;
    bus_oe_nxt   = 1'b1;
    ram_en_nxt   = 1'b0;
    ram_rw_nxt   = 1'b1;
    halt_nxt     = 1'b1;
    done_nxt     = 1'b0;
    case (state_nxt)
      S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
      S_DATA_HI, S_DATA_LO, S_CHK: in_ready_nxt = 1'b1;
      S_WRITE: begin
        ram_en_nxt = 1'b1;
        ram_rw_nxt = 1'b0;
      end
      S_RELEASE, S_FAIL: bus_oe_nxt = 1'b0;
      S_RUN: begin
        bus_oe_nxt = 1'b0;
        halt_nxt   = 1'b0;
        done_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_ADDR_HI;
      in_ready_r <= 1'b0;
      bus_oe_r   <= 1'b1;
      ram_en_r   <= 1'b0;
      ram_rw_r   <= 1'b1;
      halt_r     <= 1'b1;
      done_r     <= 1'b0;
`ifdef BAT_LOADER_CHECKSUM_EN
      err        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      in_ready_r <= in_ready_nxt;
      bus_oe_r   <= bus_oe_nxt;
      ram_en_r   <= ram_en_nxt;
      ram_rw_r   <= ram_rw_nxt;
      halt_r     <= halt_nxt;
      done_r     <= done_nxt;
`ifdef BAT_LOADER_CHECKSUM_EN
      err        <= err_nxt;
`endif
    end
  end

  // Header/word assembly; the address advances as the write strobe retires.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hi_byte <= 8'h00;
      addr    <= '0;
      count   <= 16'd0;
      data    <= '0;
`ifdef BAT_LOADER_CHECKSUM_EN
      sum     <= 8'h00;
`endif
    end else begin
`ifdef BAT_LOADER_CHECKSUM_EN
      if (state == S_GRAB)                  sum <= 8'h00;
      else if (accept && (state != S_CHK))  sum <= sum + bus.IN_BYTE;
`endif
      case (state)
        S_ADDR_HI, S_CNT_HI, S_DATA_HI: if (accept) hi_byte <= bus.IN_BYTE;
        S_ADDR_LO: if (accept) addr  <= word[ADDRESS_WIDTH-1:0];
        S_CNT_LO:  if (accept) count <= word;
        S_DATA_LO: if (accept) data  <= word;
        S_WRITE: begin
          addr  <= addr + ADDRESS_WIDTH'(1);
          count <= count - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.IN_READY = in_ready_r;
  assign bus.ADDR_OUT = addr;
  assign bus.DATA_OUT = data;
  assign bus.BUS_OE   = bus_oe_r;
  assign bus.RAM_EN   = ram_en_r;
  assign bus.RAM_RW   = ram_rw_r;
  assign bus.HALT     = halt_r;
  assign bus.DONE     = done_r;
`ifdef BAT_LOADER_CHECKSUM_EN
  assign bus.ERROR    = err;
`else
  assign bus.ERROR    = 1'b0;
`endif
endmodule

// File: tb/tb_bat_program_loader.sv
// Self-checking bench for bat_program_loader: table of images, corner sequences, random images.
module tb_bat_program_loader;
  logic CLK = 1'b0;
  logic RESET;

  bat_program_loader_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16)) bus ();
  bat_program_loader #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [7:0]  tx_q[$];
  logic [15:0] img_w[$];
  logic [31:0] wr_log[$];
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [15:0]      start;
    logic [2:0]       n;
    logic [3:0][15:0] d;
    logic [3:0][15:0] ea;
    logic [1:0]       gap;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM side: log every write strobe seen between edges.
  always @(negedge CLK) begin
    if (bus.RAM_EN === 1'b1 && bus.RAM_RW === 1'b0) begin
      wr_log.push_back({bus.ADDR_OUT, bus.DATA_OUT});
      chk("ready_low_in_write", {31'd0, bus.IN_READY}, 32'd0);
      chk("oe_high_in_write", {31'd0, bus.BUS_OE}, 32'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // gap: 0 none, 1 idle cycle after every byte, 2 random idle cycles
  task automatic send_bytes(input int gap);
    int t;
    while (tx_q.size() > 0) begin
      t = 0;
      bus.IN_BYTE  = tx_q.pop_front();
      bus.IN_VALID = 1'b1;
      while (bus.IN_READY !== 1'b1 && t < 40) begin
        @(negedge CLK);
        t++;
      end
      checks++;
      if (t >= 40) begin
        errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
        tx_q.delete();
      end
      @(negedge CLK);
      bus.IN_VALID = 1'b0;
      if (gap == 1) @(negedge CLK);
      else if (gap == 2 && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (bus.DONE !== 1'b1 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("done_reached", {31'd0, bus.DONE}, 32'd1);
  endtask

  // Byte stream from start address and img_w, MSB first, checksum appended when enabled.
  task automatic build_image(input logic [15:0] start);
    logic [15:0] n;
    n = 16'(img_w.size());
    tx_q.delete();
    tx_q.push_back(start[15:8]);
    tx_q.push_back(start[7:0]);
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    foreach (img_w[k]) begin
      tx_q.push_back(img_w[k][15:8]);
      tx_q.push_back(img_w[k][7:0]);
    end
`ifdef BAT_LOADER_CHECKSUM_EN
    begin
      logic [7:0] s;
      s = 8'h00;
      foreach (tx_q[k]) s = s + tx_q[k];
      tx_q.push_back(8'h00 - s);
    end
`endif
  endtask

  // Reference: word k lands at start+k modulo 2^16.
  task automatic model_writes(input logic [15:0] start);
    exp_q.delete();
    foreach (img_w[k]) exp_q.push_back({start + 16'(k), img_w[k]});
  endtask

  task automatic cmp_writes(input string name);
    chk({name, "_count"}, wr_log.size(), exp_q.size());
    foreach (exp_q[k]) if (k < wr_log.size()) chk(name, wr_log[k], exp_q[k]);
    wr_log.delete();
    exp_q.delete();
  endtask

  task automatic do_restart(input bit with_byte);
    bus.RESTART  = 1'b1;
    bus.IN_VALID = with_byte;
    bus.IN_BYTE  = 8'hAA;
    @(negedge CLK);
    bus.RESTART  = 1'b0;
    bus.IN_VALID = 1'b0;
    chk("grab_halt", {31'd0, bus.HALT}, 32'd1);
    chk("grab_oe", {31'd0, bus.BUS_OE}, 32'd1);
    chk("grab_done", {31'd0, bus.DONE}, 32'd0);
    chk("grab_ready", {31'd0, bus.IN_READY}, 32'd0);
    chk("grab_error", {31'd0, bus.ERROR}, 32'd0);
    @(negedge CLK);
    chk("addr_hi_ready", {31'd0, bus.IN_READY}, 32'd1);
  endtask

  task automatic basic_words();
    img_w.delete();
    img_w.push_back(16'h0005);
    img_w.push_back(16'h0000);
    img_w.push_back(16'h0001);
  endtask

  function automatic vec_t mk(input logic [15:0] st, input logic [2:0] n,
                              input logic [63:0] d, input logic [63:0] ea, input logic [1:0] gap);
    vec_t v;
    v.start = st;
    v.n     = n;
    v.d     = d;
    v.ea    = ea;
    v.gap   = gap;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(16'h0010, 3'd3, {16'h0, 16'h0001, 16'h0000, 16'h0005}, {16'h0, 16'h0012, 16'h0011, 16'h0010}, 2'd0);
    tbl[1] = mk(16'hFFFF, 3'd2, {16'h0, 16'h0, 16'h6006, 16'h400E}, {16'h0, 16'h0, 16'h0000, 16'hFFFF}, 2'd1);
    tbl[2] = mk(16'h0000, 3'd0, 64'd0, 64'd0, 2'd0);
    tbl[3] = mk(16'h0000, 3'd1, {48'h0, 16'h400E}, {48'h0, 16'h0000}, 2'd0);
    tbl[4] = mk(16'h1234, 3'd4, {16'hBEEF, 16'h0102, 16'hFFFF, 16'h8000}, {16'h1237, 16'h1236, 16'h1235, 16'h1234}, 2'd2);

    RESET = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.IN_BYTE  = 8'h00;
    bus.RESTART  = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_halt", {31'd0, bus.HALT}, 32'd1);
    chk("rst_oe", {31'd0, bus.BUS_OE}, 32'd1);
    chk("rst_ram_en", {31'd0, bus.RAM_EN}, 32'd0);
    chk("rst_ram_rw", {31'd0, bus.RAM_RW}, 32'd1);
    chk("rst_addr", {16'd0, bus.ADDR_OUT}, 32'd0);
    chk("rst_data", {16'd0, bus.DATA_OUT}, 32'd0);
    chk("rst_ready", {31'd0, bus.IN_READY}, 32'd0);
    chk("rst_done", {31'd0, bus.DONE}, 32'd0);
    chk("rst_error", {31'd0, bus.ERROR}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Table of images with hand-written expected write addresses/data.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) do_restart(i == 3);
      img_w.delete();
      for (int k = 0; k < int'(tbl[i].n); k++) img_w.push_back(tbl[i].d[k]);
      build_image(tbl[i].start);
      exp_q.delete();
      for (int k = 0; k < int'(tbl[i].n); k++) exp_q.push_back({tbl[i].ea[k], tbl[i].d[k]});
      send_bytes(int'(tbl[i].gap));
      wait_done();
      cmp_writes($sformatf("tbl%0d_writes", i));
      chk("run_halt", {31'd0, bus.HALT}, 32'd0);
      chk("run_oe", {31'd0, bus.BUS_OE}, 32'd0);
      chk("run_error", {31'd0, bus.ERROR}, 32'd0);
    end

    // Release timing after the last write of the basic image.
    do_restart(1'b0);
    basic_words();
    build_image(16'h0010);
    model_writes(16'h0010);
    begin
`ifdef BAT_LOADER_CHECKSUM_EN
      logic [7:0] ck;
      ck = tx_q.pop_back();
`endif
      send_bytes(0);
      chk("last_write_strobe", {31'd0, bus.RAM_EN}, 32'd1);
      @(negedge CLK);
`ifdef BAT_LOADER_CHECKSUM_EN
      tx_q.push_back(ck);
      send_bytes(0);
`endif
      chk("release_oe", {31'd0, bus.BUS_OE}, 32'd0);
      chk("release_halt", {31'd0, bus.HALT}, 32'd1);
      chk("release_ram_en", {31'd0, bus.RAM_EN}, 32'd0);
      @(negedge CLK);
      chk("run_halt_timing", {31'd0, bus.HALT}, 32'd0);
      chk("run_done_timing", {31'd0, bus.DONE}, 32'd1);
      cmp_writes("basic_timing");
    end

    // Reset during the write strobe of word 2.
    do_restart(1'b0);
    basic_words();
    build_image(16'h0010);
    while (tx_q.size() > 8) void'(tx_q.pop_back());
    send_bytes(0);
    chk("mid_write_strobe", {31'd0, bus.RAM_EN}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("async_ram_en", {31'd0, bus.RAM_EN}, 32'd0);
    chk("async_halt", {31'd0, bus.HALT}, 32'd1);
    chk("async_oe", {31'd0, bus.BUS_OE}, 32'd1);
    chk("async_ready", {31'd0, bus.IN_READY}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    wr_log.delete();
    @(negedge CLK);
    basic_words();
    build_image(16'h0010);
    model_writes(16'h0010);
    send_bytes(0);
    wait_done();
    cmp_writes("after_reset");

`ifdef BAT_LOADER_CHECKSUM_EN
    do_restart(1'b0);
    basic_words();
    build_image(16'h0010);
    tx_q[tx_q.size() - 1] = 8'h00;
    model_writes(16'h0010);
    send_bytes(0);
    chk("bad_ck_error", {31'd0, bus.ERROR}, 32'd1);
    chk("bad_ck_oe", {31'd0, bus.BUS_OE}, 32'd0);
    repeat (3) @(negedge CLK);
    chk("fail_halt", {31'd0, bus.HALT}, 32'd1);
    chk("fail_done", {31'd0, bus.DONE}, 32'd0);
    chk("fail_oe", {31'd0, bus.BUS_OE}, 32'd0);
    chk("fail_error", {31'd0, bus.ERROR}, 32'd1);
    cmp_writes("bad_ck_writes");
    do_restart(1'b0);
`else
    do_restart(1'b0);
`endif

    // Random images against the address/word model.
    for (int r = 0; r < 20; r++) begin
      logic [15:0] st;
      int n;
      st = ($urandom_range(0, 1) == 1) ? (16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
      n  = $urandom_range(0, 6);
      img_w.delete();
      for (int k = 0; k < n; k++) img_w.push_back(16'($urandom));
      build_image(st);
      model_writes(st);
      send_bytes(2);
      wait_done();
      cmp_writes($sformatf("rand%0d", r));
      chk("rand_halt", {31'd0, bus.HALT}, 32'd0);
      do_restart($urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
